lector_destinos: RTL and testbench
==================================

// Module: lector_destinos
// PURPOSE
// - Egress reader for the interconnect device: drains output FIFOs D0/D1 via pop_D0/pop_D1.
// - Arbitrates round-robin between ports and captures each popped word.
// - Presents words on a single registered stream with destination check and per-port word counters.
// - Sits downstream of the device's D0/D1 FIFOs; replaces ad-hoc pop driving in benches and top level.
// PARAMETERS
// - DATA_W   6   word width; bit DATA_W-2 = destination (0->D0, 1->D1), bit DATA_W-1 = VC
// - CNT_W    8   width of per-port word counters (saturating)
// PORTS
// - clk          in   1        single clock, all logic on posedge
// - reset        in   1        asynchronous, active-high; clears all state
// - enable       in   1        1 = reader may issue pops
// - D0_empty     in   1        D0 FIFO empty (registered in FIFO; reflects pops of earlier cycles)
// - D1_empty     in   1        D1 FIFO empty
// - data_out0    in   DATA_W   D0 read data, valid the cycle after pop_D0=1
// - data_out1    in   DATA_W   D1 read data, valid the cycle after pop_D1=1
// - hold         in   1        downstream stall: 1 = issue no new pops
// - pop_D0       out  1        registered pop strobe to D0
// - pop_D1       out  1        registered pop strobe to D1
// - word_out     out  DATA_W   captured word
// - valid_out    out  1        word_out valid (1-cycle pulse per word)
// - port_out     out  1        source port of word_out (0=D0, 1=D1)
// - err_dest     out  1        sticky: destination bit of a word mismatched its port
// - seq_err      out  1        sticky sequence error (see CONFIGURATION)
// - count0       out  CNT_W    words received from D0
// - count1       out  CNT_W    words received from D1
// - busy         out  1        1 while state != IDLE
// BEHAVIOUR
// - Reset values: all outputs 0, state IDLE, rr_last=1 (D0 gets first grant).
// - Pop issue: at most one pop per cycle, never both ports.
//   - Port eligible when !Dx_empty and no pop was issued to that port in the previous cycle.
//   - Empty flag lags by one edge, so this rule avoids popping an empty FIFO.
// - Grant order: round-robin; if both eligible, grant port != rr_last; if one eligible, grant it; rr_last updates on grant.
// - Latency: pop_Dx high in cycle T -> data_outx sampled at end of T+1 -> valid_out/word_out/port_out high in T+2.
// - Throughput:
//   - Both ports non-empty: one word per cycle, alternating D0,D1,D0...
//   - Single port: one word every 2 cycles.
// - FSM states:
//   - IDLE -> RUN when enable=1.
//   - RUN: issue pops while enable=1 && hold=0; on enable=0 -> FLUSH.
//   - FLUSH: no new pops; -> IDLE once no read in flight (T+1 capture done, T+2 output done); -> RUN if enable returns.
// - hold=1: stops new pops next cycle; words already popped still complete (max 2 in flight), never dropped.
// - err_dest: set when port_out != word_out[DATA_W-2] at valid_out; word still forwarded; cleared only by reset.
// - count0/count1: +1 per valid_out from that port; saturate at 2^CNT_W-1, no wrap.
// - Reset mid-operation: in-flight reads discarded; pops deassert asynchronously; counters and stickies cleared.
// CONFIGURATION
// - SEQ_CHECK_EN defined:
//   - Per-port checker expects low DATA_W-2 bits of successive words to increment by 1 mod 2^(DATA_W-2).
//   - First word after reset sets the reference; a mismatch sets seq_err (sticky).
// - SEQ_CHECK_EN undefined: checker not built; seq_err tied to 0.
// TESTING
// - Reset, D0_empty=D1_empty=1, enable=1 for 10 cycles -> no pops, valid_out=0, busy=1, counts 0.
// - D0 holds 1..4 (dest 0), D1 empty -> pop_D0 every other cycle; word_out 1,2,3,4, port_out=0, count0=4, err_dest=0.
// - Both non-empty (D0 word 0x01, D1 word 0x31) -> pops alternate D0,D1 each cycle; valid_out continuous; count0=count1.
// - Word 0x31 (dest=1) popped from D0 -> err_dest=1 next valid cycle; stays 1 until reset.
// - hold=1 after 2 pops while streaming -> 2 in-flight words still delivered, then pops stop; hold=0 resumes with no loss.
// - SEQ_CHECK_EN: D0 sequence 1,2,4 -> seq_err=1 at word 4; without macro seq_err stays 0; CNT_W=2 with 5 words -> count0=3.

Source files
------------

// File: rtl/lector_destinos_if.sv
// Egress bus for lector_destinos: FIFO-side pop/empty/data and the output word stream.
// master = the reader, slave = the FIFOs plus the downstream consumer.
interface lector_destinos_if #(
  parameter int DATA_W = 6
);
  logic              D0_empty;
  logic              D1_empty;
  logic [DATA_W-1:0] data_out0;
  logic [DATA_W-1:0] data_out1;
  logic              hold;
  logic              pop_D0;
  logic              pop_D1;
  logic [DATA_W-1:0] word_out;
  logic              valid_out;
  logic              port_out;

  modport master (
    input  D0_empty, D1_empty, data_out0, data_out1, hold,
    output pop_D0, pop_D1, word_out, valid_out, port_out
  );

  modport slave (
    output D0_empty, D1_empty, data_out0, data_out1, hold,
    input  pop_D0, pop_D1, word_out, valid_out, port_out
  );
endinterface

// File: rtl/lector_destinos.sv
// lector_destinos: round-robin egress reader draining the D0/D1 FIFOs onto a
// single registered word stream, with destination check and per-port counters.
// Optional macro SEQ_CHECK_EN builds a per-port sequence checker driving seq_err;
// without it seq_err is tied low.
// Pipeline: pop in T -> FIFO data valid in T+1 (captured at its end) -> word out in T+2.
module lector_destinos #(
  parameter int DATA_W = 6,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  lector_destinos_if.master bus,
  output logic              err_dest,
  output logic              seq_err,
  output logic [CNT_W-1:0]  count0,
  output logic [CNT_W-1:0]  count1,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state_q, state_d;
  logic              pop0_q, pop0_d;
  logic              pop1_q, pop1_d;
  logic              rr_last_q, rr_last_d;
  logic              cap_q, cap_d;          // a FIFO word is on data_outX this cycle
  logic              cap_port_q, cap_port_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              port_q, port_d;
  logic              err_q, err_d;

  logic              elig0, elig1, in_flight;
  logic [DATA_W-1:0] cap_word;

  // A port popped last cycle is skipped: its empty flag has not yet seen that pop.
  assign elig0     = !bus.D0_empty && !pop0_q;
  assign elig1     = !bus.D1_empty && !pop1_q;
  assign in_flight = pop0_q || pop1_q || cap_q || valid_q;
  assign cap_word  = cap_port_q ? bus.data_out1 : bus.data_out0;

  // Next-state and round-robin pop grant
  always_comb begin
    logic issue;
    state_d   = state_q;
    pop0_d    = 1'b0;
    pop1_d    = 1'b0;
    rr_last_d = rr_last_q;
    issue     = 1'b0;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN: begin
        if (!enable)       state_d = FLUSH;
        else if (!bus.hold) issue  = 1'b1;
      end
      FLUSH: begin
        if (enable)          state_d = RUN;
        else if (!in_flight) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      if (elig0 && (!elig1 || rr_last_q)) begin
        pop0_d    = 1'b1;
        rr_last_d = 1'b0;
      end else if (elig1) begin
        pop1_d    = 1'b1;
        rr_last_d = 1'b1;
      end
    end
  end

  // Capture stage and output register
  always_comb begin
    cap_d      = pop0_q || pop1_q;
    cap_port_d = pop1_q;
    valid_d    = cap_q;
    word_d     = word_q;
    port_d     = port_q;
    err_d      = err_q;
    if (cap_q) begin
      word_d = cap_word;
      port_d = cap_port_q;
      if (cap_port_q != cap_word[DATA_W-2]) err_d = 1'b1;
    end
  end

  // Control and datapath state; reset discards anything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pop0_q     <= 1'b0;
      pop1_q     <= 1'b0;
      rr_last_q  <= 1'b1;
      cap_q      <= 1'b0;
      cap_port_q <= 1'b0;
      valid_q    <= 1'b0;
      word_q     <= '0;
      port_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pop0_q     <= pop0_d;
      pop1_q     <= pop1_d;
      rr_last_q  <= rr_last_d;
      cap_q      <= cap_d;
      cap_port_q <= cap_port_d;
      valid_q    <= valid_d;
      word_q     <= word_d;
      port_q     <= port_d;
      err_q      <= err_d;
    end
  end

  logic [1:0][CNT_W-1:0] cnt_all;
  logic [1:0]            seq_flag;

  // Per-port saturating counter and optional sequence checker
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic             hit;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign hit = cap_q && (cap_port_q == 1'(gi));

    // Count captured words, holding at all-ones
    always_comb begin
      cnt_d = cnt_q;
      if (hit && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign cnt_all[gi] = cnt_q;

`ifdef SEQ_CHECK_EN
    localparam int SEQ_W = DATA_W - 2;
    logic [SEQ_W-1:0] last_q, last_d;
    logic             ref_q, ref_d;
    logic             serr_q, serr_d;

    // First word sets the reference; later words must step by one (mod 2^SEQ_W)
    always_comb begin
      last_d = last_q;
      ref_d  = ref_q;
      serr_d = serr_q;
      if (hit) begin
        if (ref_q && cap_word[SEQ_W-1:0] != last_q + SEQ_W'(1)) serr_d = 1'b1;
        last_d = cap_word[SEQ_W-1:0];
        ref_d  = 1'b1;
      end
    end

    // Sequence checker state
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        last_q <= '0;
        ref_q  <= 1'b0;
        serr_q <= 1'b0;
      end else begin
        last_q <= last_d;
        ref_q  <= ref_d;
        serr_q <= serr_d;
      end
    end

    assign seq_flag[gi] = serr_q;
`else
    assign seq_flag[gi] = 1'b0;
`endif
  end

  assign bus.pop_D0    = pop0_q;
  assign bus.pop_D1    = pop1_q;
  assign bus.word_out  = word_q;
  assign bus.valid_out = valid_q;
  assign bus.port_out  = port_q;
  assign err_dest      = err_q;
  assign seq_err       = |seq_flag;
  assign count0        = cnt_all[0];
  assign count1        = cnt_all[1];
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_lector_destinos.sv
// Bench for lector_destinos: FIFO models feed D0/D1, stimulus pushes expected
// words into per-port scoreboards, a negedge monitor pops and compares.
module tb_lector_destinos;
  localparam int DATA_W = 6;
  localparam int CNT_W  = 3;   // small so saturation at 7 is reachable

`ifdef SEQ_CHECK_EN
  localparam logic SEQ_ON = 1'b1;
`else
  localparam logic SEQ_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  logic enable;
  logic err_dest, seq_err, busy;
  logic [CNT_W-1:0] count0, count1;

  lector_destinos_if #(.DATA_W(DATA_W)) bus ();

  lector_destinos #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .bus      (bus),
    .err_dest (err_dest),
    .seq_err  (seq_err),
    .count0   (count0),
    .count1   (count1),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [DATA_W-1:0] fifo0[$], fifo1[$];   // FIFO contents
  logic [DATA_W-1:0] exp0[$], exp1[$];     // scoreboard
  int                valid_cyc[$];         // cycle of each output word
  logic              port_log[$];          // port of each output word
  int                cyc = 0;
  logic              prev0 = 1'b0, prev1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // FIFO model: data valid the cycle after a pop, empty flag registered
  always @(posedge clk) begin
    if (reset) begin
      bus.D0_empty  <= 1'b1;
      bus.D1_empty  <= 1'b1;
      bus.data_out0 <= '0;
      bus.data_out1 <= '0;
    end else begin
      if (bus.pop_D0 && fifo0.size() > 0) bus.data_out0 <= fifo0.pop_front();
      if (bus.pop_D1 && fifo1.size() > 0) bus.data_out1 <= fifo1.pop_front();
      bus.D0_empty <= (fifo0.size() == 0);
      bus.D1_empty <= (fifo1.size() == 0);
    end
  end

  // Monitor: pop legality and scoreboard comparison
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev0 = 1'b0;
      prev1 = 1'b0;
    end else begin
      if (bus.pop_D0 || bus.pop_D1) check("pop_exclusive", {31'd0, bus.pop_D0 & bus.pop_D1}, 0);
      if (bus.pop_D0) check("pop_D0_back_to_back", {31'd0, prev0}, 0);
      if (bus.pop_D1) check("pop_D1_back_to_back", {31'd0, prev1}, 0);
      prev0 = bus.pop_D0;
      prev1 = bus.pop_D1;
      if (bus.valid_out) begin
        valid_cyc.push_back(cyc);
        port_log.push_back(bus.port_out);
        if (bus.port_out == 1'b0) begin
          if (exp0.size() == 0) check("scoreboard_D0_nonempty", 0, 1);
          else check("word_D0", {26'd0, bus.word_out}, {26'd0, exp0.pop_front()});
        end else begin
          if (exp1.size() == 0) check("scoreboard_D1_nonempty", 0, 1);
          else check("word_D1", {26'd0, bus.word_out}, {26'd0, exp1.pop_front()});
        end
        $display("word %02h port %0d cyc %0d", bus.word_out, bus.port_out, cyc);
      end
    end
  end

  task automatic push0(input logic [DATA_W-1:0] w);
    fifo0.push_back(w);
    exp0.push_back(w);
  endtask

  task automatic push1(input logic [DATA_W-1:0] w);
    fifo1.push_back(w);
    exp1.push_back(w);
  endtask

  task automatic wait_rx(input int target, input string name);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (port_log.size() >= target) break;
    end
    repeat (3) @(negedge clk);
    check(name, port_log.size(), target);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int base, npops, k;
    logic [DATA_W-1:0] w;
    reset = 1'b1;
    enable = 1'b0;
    bus.hold = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pop", {30'd0, bus.pop_D1, bus.pop_D0}, 0);
    check("rst_valid", {31'd0, bus.valid_out}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_err", {30'd0, seq_err, err_dest}, 0);
    check("rst_counts", {26'd0, count1, count0}, 0);
    reset = 1'b0;

    // Both FIFOs empty, enabled: no pops, busy
    enable = 1'b1;
    npops = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.pop_D0 || bus.pop_D1) npops++;
    end
    check("empty_pops", npops, 0);
    check("empty_words", port_log.size(), 0);
    check("empty_busy", {31'd0, busy}, 1);
    check("empty_count0", {29'd0, count0}, 0);

    // D0 only: 1..4, one word every two cycles
    base = port_log.size();
    for (int i = 1; i <= 4; i++) push0(DATA_W'(i));
    wait_rx(base + 4, "d0_only_rx");
    check("d0_only_spacing", valid_cyc[base + 3] - valid_cyc[base], 6);
    check("d0_only_count0", {29'd0, count0}, 4);
    check("d0_only_count1", {29'd0, count1}, 0);
    check("d0_only_err", {31'd0, err_dest}, 0);

    // Both FIFOs: alternate D1,D0,... (last grant was D0), back-to-back words
    base = port_log.size();
    for (int i = 0; i < 3; i++) begin
      push0(DATA_W'(6'h05 + i));
      push1(DATA_W'(6'h31 + i));
    end
    wait_rx(base + 6, "both_rx");
    check("both_contiguous", valid_cyc[base + 5] - valid_cyc[base], 5);
    for (int i = 0; i < 6; i++) check("both_port_order", {31'd0, port_log[base + i]}, (i % 2 == 0) ? 1 : 0);
    check("both_count0_sat", {29'd0, count0}, 7);
    check("both_count1", {29'd0, count1}, 3);
    check("both_seq_clean", {31'd0, seq_err}, 0);
    check("both_err", {31'd0, err_dest}, 0);

    // Misrouted word 0x31 on D0 sets sticky err_dest; count0 stays saturated
    base = port_log.size();
    push0(6'h31);
    wait_rx(base + 1, "misroute_rx");
    check("misroute_err", {31'd0, err_dest}, 1);
    check("misroute_seq", {31'd0, seq_err}, {31'd0, SEQ_ON});
    push0(6'h02);
    wait_rx(base + 2, "misroute_next_rx");
    check("misroute_err_sticky", {31'd0, err_dest}, 1);
    check("count0_saturated", {29'd0, count0}, 7);

    // Reset clears counters and stickies; then hold after two pops
    pulse_reset();
    check("rst2_err", {30'd0, seq_err, err_dest}, 0);
    check("rst2_counts", {26'd0, count1, count0}, 0);
    base = port_log.size();
    for (int i = 1; i <= 4; i++) begin
      push0(DATA_W'(i));
      push1(DATA_W'(6'h10 + i));
    end
    npops = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.pop_D0 || bus.pop_D1) npops++;
      if (npops == 2) break;
    end
    bus.hold = 1'b1;
    check("hold_prepops", npops, 2);
    npops = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.pop_D0 || bus.pop_D1) npops++;
    end
    check("hold_no_pops", npops, 0);
    check("hold_inflight_delivered", port_log.size() - base, 2);
    bus.hold = 1'b0;
    wait_rx(base + 8, "hold_resume_rx");
    check("hold_count0", {29'd0, count0}, 4);
    check("hold_count1", {29'd0, count1}, 4);
    check("hold_err", {31'd0, err_dest}, 0);
    check("hold_seq", {31'd0, seq_err}, 0);

    // Disable: flush then idle
    enable = 1'b0;
    npops = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.pop_D0 || bus.pop_D1) npops++;
      if (!busy) break;
    end
    check("flush_idle", {31'd0, busy}, 0);
    check("flush_pops", npops, 0);

    // Sequence 1,2,4 on D0
    pulse_reset();
    enable = 1'b1;
    base = port_log.size();
    push0(6'h01);
    push0(6'h02);
    push0(6'h04);
    wait_rx(base + 3, "seq_rx");
    check("seq_gap", {31'd0, seq_err}, {31'd0, SEQ_ON});
    check("seq_count0", {29'd0, count0}, 3);

    check("sb_drained_D0", exp0.size(), 0);
    check("sb_drained_D1", exp1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
